// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the memory-access stage and the BIU.
//   master : memory-access stage (drives request, address, write data/strobes)
//   slave  : BIU (drives grant, response valid, read data)
// Ports:
//   bus_req     request, held with all request fields until bus_gnt
//   bus_we      1 = write
//   bus_addr    word-aligned byte address
//   bus_wstrb   byte-lane strobes (0 for reads)
//   bus_wdata   lane-replicated write data
//   bus_gnt     BIU accepted the request
//   bus_rvalid  response (read data or write acknowledge)
//   bus_rdata   read data
interface mem_access_unit_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage of the RISC-V core (between ALU and write-back).
// Non-memory instructions pass straight to write-back with one register
// stage. Loads/stores run one request/grant/response transaction on the
// data bus; the stage stalls (in_ready low) until the response arrives.
// Misaligned halfword/word accesses are dropped with a misalign_o pulse.
// Ports:
//   clk, rst_n            core clock, synchronous active-low reset
//   in_valid / in_ready   ALU-stage handshake (ready only when idle)
//   in_pc, in_inst        pc / instruction (funct3 = in_inst[14:12])
//   in_reg_wdata          ALU result for non-load write-back
//   in_wr_reg_en/_addr    register write request
//   in_load, in_store     memory operation type
//   in_mem_addr           effective byte address
//   in_wr_mem_data        store data (rs2)
//   bus                   data-bus interface (master side)
//   wb_*                  write-back entry, wb_valid pulses per result
//   misalign_o            one-cycle pulse when a misaligned access is dropped
module mem_access_unit (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_pc,
   input  logic [31:0]             in_inst,
   input  logic [31:0]             in_reg_wdata,
   input  logic                    in_wr_reg_en,
   input  logic [4:0]              in_wr_reg_addr,
   input  logic                    in_load,
   input  logic                    in_store,
   input  logic [31:0]             in_mem_addr,
   input  logic [31:0]             in_wr_mem_data,
   mem_access_unit_if.master       bus,
   output logic                    wb_valid,
   output logic [31:0]             wb_pc,
   output logic [31:0]             wb_inst,
   output logic                    wb_wr_reg_en,
   output logic [4:0]              wb_wr_reg_addr,
   output logic [31:0]             wb_reg_wdata,
   output logic                    misalign_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

   state_t      state_q, state_d;

   // request fields captured at acceptance, used when the response returns
   logic [31:0] pc_p1;
   logic [31:0] inst_p1;
   logic [4:0]  rd_p1;
   logic        rd_en_p1;
   logic [1:0]  idx_p1;

   logic [31:0] bus_addr_q;
   logic [31:0] bus_wdata_q;
   logic [3:0]  bus_wstrb_q;
   logic        bus_we_q;

   logic        is_mem;
   logic        is_mis;
   logic        accept;

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] idx);
      misaligned = ((f3[1:0] == 2'b01) && idx[0]) ||
                   ((f3[1:0] == 2'b10) && (idx != 2'b00));
   endfunction

   function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] idx);
      case (f3[1:0])
         2'b00:   store_strobe = 4'b0001 << idx;
         2'b01:   store_strobe = 4'b0011 << idx;
         2'b10:   store_strobe = 4'b1111;
         default: store_strobe = 4'b0000;
      endcase
   endfunction

   // Replicating across lanes lets the BIU pick the strobed lanes directly.
   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
      case (f3[1:0])
         2'b00:   store_data = {4{rs2[7:0]}};
         2'b01:   store_data = {2{rs2[15:0]}};
         default: store_data = rs2;
      endcase
   endfunction

   // Aligned LW always has idx=0, so the shifted word equals bus_rdata.
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] idx,
                                               input logic [31:0] rdata);
      logic [31:0] sh;
      sh = rdata >> {idx, 3'b000};
      case (f3)
         3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
         3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
         3'b010:  load_extend = sh;
         3'b100:  load_extend = {24'd0, sh[7:0]};
         3'b101:  load_extend = {16'd0, sh[15:0]};
         default: load_extend = 32'd0;
      endcase
   endfunction

   assign is_mem = in_load | in_store;
   assign is_mis = is_mem & misaligned(in_inst[14:12], in_mem_addr[1:0]);
   assign accept = in_valid & (state_q == S_IDLE);

   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_wdata = bus_wdata_q;
   assign bus.bus_wstrb = bus_wstrb_q;
   assign bus.bus_we    = bus_we_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready    = 1'b0;
      bus.bus_req = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && is_mem && !is_mis) state_d = S_REQ;
         end
         S_REQ: begin
            bus.bus_req = 1'b1;
            if (bus.bus_gnt) state_d = S_RSP;
         end
         S_RSP: begin
            if (bus.bus_rvalid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---- acceptance stage: capture request fields ----
   always_ff @(posedge clk) begin
      if (accept && is_mem && !is_mis) begin
         pc_p1    <= in_pc;
         inst_p1  <= in_inst;
         rd_p1    <= in_wr_reg_addr;
         rd_en_p1 <= in_wr_reg_en;
         idx_p1   <= in_mem_addr[1:0];
      end
   end

   // ---- bus request and write-back registers ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_addr_q     <= 32'd0;
         bus_wdata_q    <= 32'd0;
         bus_wstrb_q    <= 4'd0;
         bus_we_q       <= 1'b0;
         wb_valid       <= 1'b0;
         wb_pc          <= 32'd0;
         wb_inst        <= 32'd0;
         wb_wr_reg_en   <= 1'b0;
         wb_wr_reg_addr <= 5'd0;
         wb_reg_wdata   <= 32'd0;
         misalign_o     <= 1'b0;
      end else begin
         wb_valid   <= 1'b0;
         misalign_o <= 1'b0;
         if (accept) begin
            if (!is_mem || is_mis) begin
               wb_valid       <= 1'b1;
               misalign_o     <= is_mis;
               wb_pc          <= in_pc;
               wb_inst        <= in_inst;
               wb_wr_reg_addr <= in_wr_reg_addr;
               wb_wr_reg_en   <= in_wr_reg_en & ~is_mem;
               if (!is_mem) wb_reg_wdata <= in_reg_wdata;
            end else begin
               bus_addr_q  <= {in_mem_addr[31:2], 2'b00};
               bus_we_q    <= in_store;
               bus_wstrb_q <= in_store ? store_strobe(in_inst[14:12], in_mem_addr[1:0]) : 4'b0000;
               bus_wdata_q <= store_data(in_inst[14:12], in_wr_mem_data);
            end
         end
         if ((state_q == S_RSP) && bus.bus_rvalid) begin
            wb_valid       <= 1'b1;
            wb_pc          <= pc_p1;
            wb_inst        <= inst_p1;
            wb_wr_reg_addr <= rd_p1;
            wb_wr_reg_en   <= rd_en_p1 & ~bus_we_q;
            if (!bus_we_q) wb_reg_wdata <= load_extend(inst_p1[14:12], idx_p1, bus.bus_rdata);
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int DEPTH = 8192;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc, in_inst, in_reg_wdata;
   logic        in_wr_reg_en;
   logic [4:0]  in_wr_reg_addr;
   logic        in_load, in_store;
   logic [31:0] in_mem_addr, in_wr_mem_data;
   logic        wb_valid;
   logic [31:0] wb_pc, wb_inst;
   logic        wb_wr_reg_en;
   logic [4:0]  wb_wr_reg_addr;
   logic [31:0] wb_reg_wdata;
   logic        misalign_o;

   mem_access_unit_if bus();

   mem_access_unit dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .in_reg_wdata(in_reg_wdata),
      .in_wr_reg_en(in_wr_reg_en), .in_wr_reg_addr(in_wr_reg_addr),
      .in_load(in_load), .in_store(in_store),
      .in_mem_addr(in_mem_addr), .in_wr_mem_data(in_wr_mem_data),
      .bus(bus),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
      .wb_wr_reg_en(wb_wr_reg_en), .wb_wr_reg_addr(wb_wr_reg_addr),
      .wb_reg_wdata(wb_reg_wdata), .misalign_o(misalign_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit chk_on = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Timeline of expected observations, indexed by the number of clock edges seen.
   bit exp_req   [DEPTH];
   bit exp_ready [DEPTH];
   bit exp_wbv   [DEPTH];
   bit exp_mis   [DEPTH];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] data;
      logic        wen;
      logic [4:0]  rd;
      bit          chk_data;
   } wb_t;
   wb_t wbq[$];

   logic [31:0] e_addr, e_wdata;
   logic        e_we;
   logic [3:0]  e_wstrb;

   logic [31:0] l_addr, l_wdata;
   logic        l_we;
   logic [3:0]  l_wstrb;
   int          req_cnt = 0;
   int          wbv_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 1;
      endcase
   endfunction

   function automatic bit is_mis(input logic [2:0] f3, input logic [1:0] idx);
      return (int'(idx) % size_of(f3)) != 0;
   endfunction

   function automatic logic [3:0] strobe(input logic [2:0] f3, input logic [1:0] idx);
      logic [3:0] s;
      int sz;
      s  = 4'd0;
      sz = size_of(f3);
      for (int i = 0; i < 4; i++)
         if (i >= int'(idx) && i < int'(idx) + sz) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] rs2);
      logic [31:0] w;
      int sz;
      w  = 32'd0;
      sz = size_of(f3);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % sz) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] idx,
                                            input logic [31:0] rdata);
      logic [31:0] sh;
      int b, h;
      sh = rdata >> (8 * int'(idx));
      b  = int'(sh & 32'hFF);
      h  = int'(sh & 32'hFFFF);
      case (f3)
         3'd0:    return (b >= 128)   ? 32'(b - 256)   : 32'(b);
         3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
         3'd2:    return rdata;
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin : cmp
      int  c;
      wb_t e;
      if (chk_on) begin
         c = cyc;
         chk1("in_ready", in_ready, exp_ready[c]);
         chk1("bus_req", bus.bus_req, exp_req[c]);
         chk1("wb_valid", wb_valid, exp_wbv[c]);
         chk1("misalign_o", misalign_o, exp_mis[c]);
         if (bus.bus_req) begin
            req_cnt++;
            l_addr  = bus.bus_addr;
            l_wdata = bus.bus_wdata;
            l_we    = bus.bus_we;
            l_wstrb = bus.bus_wstrb;
            if (exp_req[c]) begin
               chk("bus_addr", bus.bus_addr, e_addr);
               chk1("bus_we", bus.bus_we, e_we);
               chk("bus_wstrb", 32'(bus.bus_wstrb), 32'(e_wstrb));
               if (e_we) chk("bus_wdata", bus.bus_wdata, e_wdata);
            end
         end
         if (wb_valid) begin
            wbv_cnt++;
            if (exp_wbv[c]) begin
               if (wbq.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL wb_queue: got wb_valid, expected no pending entry (t=%0t)", $time);
               end else begin
                  e = wbq.pop_front();
                  chk("wb_pc", wb_pc, e.pc);
                  chk("wb_inst", wb_inst, e.inst);
                  chk1("wb_wr_reg_en", wb_wr_reg_en, e.wen);
                  chk("wb_wr_reg_addr", 32'(wb_wr_reg_addr), 32'(e.rd));
                  if (e.chk_data) chk("wb_reg_wdata", wb_reg_wdata, e.data);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic noise_inputs();
      in_valid       = 1'($urandom_range(0, 1));
      in_pc          = $urandom;
      in_inst        = $urandom;
      in_reg_wdata   = $urandom;
      in_wr_reg_en   = 1'($urandom_range(0, 1));
      in_wr_reg_addr = 5'($urandom);
      in_load        = 1'($urandom_range(0, 1));
      in_store       = 1'($urandom_range(0, 1));
      in_mem_addr    = $urandom;
      in_wr_mem_data = $urandom;
   endtask

   // Called just after a clock edge with the DUT idle; returns just after the
   // edge on which the result is written back (DUT idle again).
   task automatic do_txn(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] regw,
                         input logic wen, input logic [4:0] rd, input logic ld, input logic st,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input int g, input int r, input logic [31:0] rdata);
      int         a;
      logic [2:0] f3;
      logic [1:0] idx;
      bit         mis;
      wb_t        e;
      a   = cyc + 1;
      f3  = inst[14:12];
      idx = addr[1:0];
      mis = (ld || st) && is_mis(f3, idx);
      in_valid = 1'b1; in_pc = pc; in_inst = inst; in_reg_wdata = regw;
      in_wr_reg_en = wen; in_wr_reg_addr = rd; in_load = ld; in_store = st;
      in_mem_addr = addr; in_wr_mem_data = rs2;
      e.pc = pc; e.inst = inst; e.rd = rd;
      if (!(ld || st) || mis) begin
         e.wen = wen && !mis; e.data = regw; e.chk_data = !mis;
         exp_wbv[a] = 1'b1;
         exp_mis[a] = mis;
         wbq.push_back(e);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end else begin
         e_addr  = {addr[31:2], 2'b00};
         e_we    = st;
         e_wstrb = st ? strobe(f3, idx) : 4'b0000;
         e_wdata = replicate(f3, rs2);
         for (int i = 0; i <= g; i++) exp_req[a + i] = 1'b1;
         for (int k = a; k <= a + 1 + g + r; k++) exp_ready[k] = 1'b0;
         exp_wbv[a + 2 + g + r] = 1'b1;
         e.wen = ld ? wen : 1'b0;
         e.data = load_val(f3, idx, rdata);
         e.chk_data = ld;
         wbq.push_back(e);
         @(posedge clk); #1;
         for (int i = 0; i <= g; i++) begin
            noise_inputs();
            bus.bus_gnt    = (i == g);
            bus.bus_rvalid = 1'($urandom_range(0, 1));
            bus.bus_rdata  = $urandom;
            @(posedge clk); #1;
         end
         for (int j = 0; j <= r; j++) begin
            noise_inputs();
            bus.bus_gnt    = 1'($urandom_range(0, 1));
            bus.bus_rvalid = (j == r);
            bus.bus_rdata  = (j == r) ? rdata : $urandom;
            @(posedge clk); #1;
         end
         in_valid = 1'b0; bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk1({tag, "_in_ready"}, in_ready, 1'b1);
      chk1({tag, "_bus_req"}, bus.bus_req, 1'b0);
      chk1({tag, "_bus_we"}, bus.bus_we, 1'b0);
      chk({tag, "_bus_wstrb"}, 32'(bus.bus_wstrb), 32'd0);
      chk({tag, "_bus_addr"}, bus.bus_addr, 32'd0);
      chk({tag, "_bus_wdata"}, bus.bus_wdata, 32'd0);
      chk1({tag, "_wb_valid"}, wb_valid, 1'b0);
      chk1({tag, "_wb_wr_reg_en"}, wb_wr_reg_en, 1'b0);
      chk({tag, "_wb_wr_reg_addr"}, 32'(wb_wr_reg_addr), 32'd0);
      chk({tag, "_wb_reg_wdata"}, wb_reg_wdata, 32'd0);
      chk({tag, "_wb_pc"}, wb_pc, 32'd0);
      chk({tag, "_wb_inst"}, wb_inst, 32'd0);
      chk1({tag, "_misalign_o"}, misalign_o, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : drv
      int a;
      int lf3[7] = '{0, 1, 2, 3, 4, 5, 7};
      logic [31:0] inst;
      int kind;
      for (int i = 0; i < DEPTH; i++) exp_ready[i] = 1'b1;
      rst_n = 1'b0;
      in_valid = 1'b0; in_pc = 0; in_inst = 0; in_reg_wdata = 0; in_wr_reg_en = 0;
      in_wr_reg_addr = 0; in_load = 0; in_store = 0; in_mem_addr = 0; in_wr_mem_data = 0;
      bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // ADD x5 = 0x1234, two back-to-back
      do_txn(32'h100, 32'h002082B3, 32'h1234, 1'b1, 5'd5, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      do_txn(32'h104, 32'h002082B3, 32'h1234, 1'b1, 5'd5, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("add_wdata", wb_reg_wdata, 32'h0000_1234);
      chk("add_rd", 32'(wb_wr_reg_addr), 32'd5);
      chk1("add_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // LB / LBU at 0x1003
      do_txn(32'h200, 32'h00000003, 0, 1'b1, 5'd10, 1'b1, 1'b0, 32'h1003, 0, 0, 0, 32'h80AA_BBCC);
      @(negedge clk);
      chk("lb_wdata", wb_reg_wdata, 32'hFFFF_FF80);
      chk("lb_addr", l_addr, 32'h0000_1000);
      chk("lb_wstrb", 32'(l_wstrb), 32'd0);
      @(posedge clk); #1;
      do_txn(32'h204, 32'h00004003, 0, 1'b1, 5'd11, 1'b1, 1'b0, 32'h1003, 0, 0, 0, 32'h80AA_BBCC);
      @(negedge clk);
      chk("lbu_wdata", wb_reg_wdata, 32'h0000_0080);
      @(posedge clk); #1;

      // SH at 0x2002
      do_txn(32'h300, 32'h00001023, 0, 1'b1, 5'd3, 1'b0, 1'b1, 32'h2002, 32'h1234_ABCD, 0, 0, 0);
      @(negedge clk);
      chk1("sh_we", l_we, 1'b1);
      chk("sh_wstrb", 32'(l_wstrb), 32'hC);
      chk("sh_wdata", l_wdata, 32'hABCD_ABCD);
      chk1("sh_wren", wb_wr_reg_en, 1'b0);
      @(posedge clk); #1;

      // LW with 3 grant waits and 2 response waits
      req_cnt = 0; wbv_cnt = 0;
      do_txn(32'h400, 32'h00002003, 0, 1'b1, 5'd12, 1'b1, 1'b0, 32'h3000, 0, 3, 2, 32'hCAFE_F00D);
      @(negedge clk);
      chk("lw_wdata", wb_reg_wdata, 32'hCAFE_F00D);
      @(posedge clk); #1;
      chk("lw_req_cycles", 32'(req_cnt), 32'd4);
      chk("lw_wb_count", 32'(wbv_cnt), 32'd1);

      // misaligned LW at 0x3002
      req_cnt = 0;
      do_txn(32'h500, 32'h00002003, 0, 1'b1, 5'd13, 1'b1, 1'b0, 32'h3002, 0, 0, 0, 0);
      @(negedge clk);
      chk1("mis_pulse", misalign_o, 1'b1);
      chk1("mis_wbv", wb_valid, 1'b1);
      chk1("mis_wren", wb_wr_reg_en, 1'b0);
      @(posedge clk); #1;
      chk("mis_req_cycles", 32'(req_cnt), 32'd0);

      // reset while waiting for the response, then a late rvalid
      a = cyc + 1;
      in_valid = 1'b1; in_pc = 32'h600; in_inst = 32'h00002003; in_wr_reg_en = 1'b1;
      in_wr_reg_addr = 5'd7; in_load = 1'b1; in_store = 1'b0; in_mem_addr = 32'h4000;
      e_addr = 32'h4000; e_we = 1'b0; e_wstrb = 4'd0;
      exp_req[a] = 1'b1; exp_ready[a] = 1'b0; exp_ready[a + 1] = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; bus.bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus.bus_gnt = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check_reset_vals("midrst");
      @(posedge clk); #1;
      bus.bus_rvalid = 1'b0;
      do_txn(32'h700, 32'h002082B3, 32'h5A5A_0001, 1'b1, 5'd9, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("post_rst_add", wb_reg_wdata, 32'h5A5A_0001);
      @(posedge clk); #1;

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 2);
         inst = $urandom;
         if (kind == 1)      inst[14:12] = 3'(lf3[$urandom_range(0, 6)]);
         else if (kind == 2) inst[14:12] = 3'($urandom_range(0, 2));
         do_txn($urandom, inst, $urandom, 1'($urandom_range(0, 1)), 5'($urandom),
                kind == 1, kind == 2, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("wb_queue_drained", 32'(wbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
